mdu_iterative: RTL

//  Iterative RV32M multiply/divide unit in the execute slot beside the ALU.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_iterative.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants and state encoding for the iterative multiply/divide unit
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - radix-2 iterative RV32M multiply/divide unit
module mdu_iterative #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);
  import mdu_pkg::*;

  state_t            state, state_nxt;
  logic [2*XLEN-1:0] work;     // multiply: {acc, multiplier}; divide: low half dividend -> quotient
  logic [XLEN-1:0]   rem;      // restored partial remainder, always below the divisor
  logic [XLEN-1:0]   opnd;     // |A| for multiply, |B| for divide
  logic [CNT_W-1:0]  cnt;
  logic              sign_a, sign_b;
  logic [2:0]        op;

  logic              a_signed, b_signed, sa, sb, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;

  // Decode the incoming request: operand magnitudes, signs and the divide corner cases.
  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
               (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa       = a_signed & rs1_data[XLEN-1];
    sb       = b_signed & rs2_data[XLEN-1];
    a_mag    = sa ? -rs1_data : rs1_data;
    b_mag    = sb ? -rs2_data : rs2_data;
    div_zero = (rs2_data == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    special  = is_div & (div_zero | div_ovf);
    if (div_zero) special_res = funct3[1] ? rs1_data : '1;
    else          special_res = funct3[1] ? '0 : rs1_data;
  end

  logic [XLEN:0]   add_x, add_y;
  logic            add_sub;
  logic [XLEN+1:0] add_sum;

  // Shared adder: accumulate for multiply, trial subtract for divide (top bit = no borrow).
  always_comb begin
    add_y   = {1'b0, opnd};
    add_sub = op[2];
    if (op[2]) add_x = {rem, work[XLEN-1]};
    else       add_x = {1'b0, work[2*XLEN-1:XLEN]};
    add_sum = {1'b0, add_x} + {1'b0, add_sub ? ~add_y : add_y} +
              {{(XLEN+1){1'b0}}, add_sub};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Sign correction and result selection for the FIX step.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -work : work;
    quo_fix  = (sign_a ^ sign_b) ? -work[XLEN-1:0] : work[XLEN-1:0];
    rem_fix  = sign_a ? -rem : rem;
    case (op)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = special ? ST_DONE : ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(XLEN-1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        busy      = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign wb_en = done & (wb_addr != 5'd0);

  // Datapath: latch the request, iterate one bit per cycle, load the corrected result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      rem     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      op      <= '0;
      result  <= '0;
      wb_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          op      <= funct3;
          wb_addr <= rd_addr;
          cnt     <= '0;
          sign_a  <= sa;
          sign_b  <= sb;
          rem     <= '0;
          if (special) begin
            result <= special_res;
          end else if (is_div) begin
            work <= {{XLEN{1'b0}}, a_mag};
            opnd <= b_mag;
          end else begin
            work <= {{XLEN{1'b0}}, b_mag};
            opnd <= a_mag;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (op[2]) begin
            rem  <= add_sum[XLEN+1] ? add_sum[XLEN-1:0] : add_x[XLEN-1:0];
            work <= {work[2*XLEN-1:XLEN], work[XLEN-2:0], add_sum[XLEN+1]};
          end else begin
            work <= {(work[0] ? add_sum[XLEN:0] : {1'b0, work[2*XLEN-1:XLEN]}),
                     work[XLEN-1:1]};
          end
        end
        ST_FIX: result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
